// File: rtl/motor_pkg.sv
// Shared register map, widths and sequencer state encoding for the motor controller
// master/slave pair, plus the ramp decision rule used after every accepted command or write.
package motor_pkg;

    localparam logic REG_DIR    = 1'b0;
    localparam logic REG_DUTY   = 1'b1;
    localparam int   DIR_W      = 12;
    localparam int   DUTY_W     = 5;
    localparam int   NUM_MOTORS = 6;

    typedef enum logic [2:0] {
        ST_INIT_DIR,
        ST_INIT_DUTY,
        ST_IDLE,
        ST_WAIT,
        ST_WR_DUTY,
        ST_WR_DIR
    } state_t;

    // A pending direction change on a running motor set forces the ramp target to zero.
    function automatic logic [DUTY_W-1:0] step_goal(input logic pending,
                                                    input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] goal;
        goal = (pending && cur != '0) ? '0 : tgt;
        return goal;
    endfunction

    function automatic state_t decide(input logic pending,
                                      input logic [DUTY_W-1:0] cur,
                                      input logic [DUTY_W-1:0] tgt);
        state_t nxt;
        if (pending && cur == '0)
            nxt = ST_WR_DIR;
        else if (cur != step_goal(pending, cur, tgt))
            nxt = ST_WAIT;
        else
            nxt = ST_IDLE;
        return nxt;
    endfunction

endpackage

// File: rtl/ramp_step_timer.sv
// Inter-step delay counter: load sets STEP_CYCLES-1, dec counts down to zero and holds.
// done_o is high whenever the count is zero.
module ramp_step_timer #(
    parameter  int STEP_CYCLES = 50000,
    localparam int STEP_W      = $clog2(STEP_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    logic [STEP_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= STEP_W'(STEP_CYCLES - 1);
        else if (dec_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/motor_ramp_master.sv
// Avalon-MM master that initialises the motor slave and ramps its duty one step per STEP_CYCLES,
// dropping to zero duty before any direction change on a running motor set.
module motor_ramp_master
    import motor_pkg::*;
#(
    parameter  int STEP_CYCLES = 50000,
    localparam int STEP_W      = $clog2(STEP_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIR_W-1:0]  cmd_dir_en,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [DUTY_W-1:0] cur_duty
);

    state_t            state_q, state_d;
    logic [DIR_W-1:0]  cur_dir_q, cur_dir_d, tgt_dir_q, tgt_dir_d;
    logic [DUTY_W-1:0] cur_duty_q, cur_duty_d, tgt_duty_q, tgt_duty_d;
    logic [DUTY_W-1:0] goal, nxt;
    logic              dir_pending, timer_load, timer_dec, timer_done;
    logic              wr, addr;
    logic [31:0]       wdata;

    ramp_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timer_load),
        .dec_i  (timer_dec),
        .done_o (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT_DIR;
            cur_dir_q  <= '0;
            cur_duty_q <= '0;
            tgt_dir_q  <= '0;
            tgt_duty_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            cur_duty_q <= cur_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
        end
    end

    assign dir_pending = (tgt_dir_q != cur_dir_q);
    assign goal        = step_goal(dir_pending, cur_duty_q, tgt_duty_q);
    assign nxt         = (goal > cur_duty_q) ? cur_duty_q + 1'b1 : cur_duty_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        cur_duty_d = cur_duty_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        timer_dec  = 1'b0;
        wr         = 1'b0;
        addr       = REG_DIR;
        wdata      = '0;
        unique case (state_q)
            ST_INIT_DIR: begin
                wr = 1'b1;
                if (!avm_waitrequest) state_d = ST_INIT_DUTY;
            end
            ST_INIT_DUTY: begin
                wr   = 1'b1;
                addr = REG_DUTY;
                if (!avm_waitrequest) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_dir_d  = cmd_dir_en;
                    tgt_duty_d = cmd_duty;
                    state_d    = decide(cmd_dir_en != cur_dir_q, cur_duty_q, cmd_duty);
                end
            end
            ST_WAIT: begin
                timer_dec = 1'b1;
                if (timer_done) state_d = ST_WR_DUTY;
            end
            ST_WR_DUTY: begin
                wr    = 1'b1;
                addr  = REG_DUTY;
                wdata = {27'b0, nxt};
                if (!avm_waitrequest) begin
                    cur_duty_d = nxt;
                    state_d    = decide(dir_pending, nxt, tgt_duty_q);
                end
            end
            ST_WR_DIR: begin
                wr    = 1'b1;
                wdata = {20'b0, tgt_dir_q};
                if (!avm_waitrequest) begin
                    cur_dir_d = tgt_dir_q;
                    state_d   = decide(1'b0, cur_duty_q, tgt_duty_q);
                end
            end
            default: state_d = ST_INIT_DIR;
        endcase
    end

    // Reload only on entry so the count runs down undisturbed while waiting.
    assign timer_load = (state_d == ST_WAIT) && (state_q != ST_WAIT);

    // Reset silences the bus immediately, even mid-stall, since the interconnect shares it.
    assign avm_write     = wr && !reset;
    assign avm_address   = addr && !reset;
    assign avm_writedata = reset ? 32'h0 : wdata;
    assign cmd_ready     = (state_q == ST_IDLE) && !reset;
    assign busy          = (state_q != ST_IDLE) || reset;
    assign cur_duty      = cur_duty_q;

endmodule

// File: doc/motor_ramp_master.md
# motor_ramp_master

Avalon-MM master that drives the motor controller's two-register slave (direction/enable and duty cycle) on behalf of on-chip logic rather than the CPU. It accepts a target direction/enable word and target duty cycle over a valid/ready command port and sequences bus writes so that duty changes ramp one step at a time. A direction change on a running motor set is always preceded by a ramp to zero duty. After reset it writes both slave registers to zero, since the slave itself has no reset.

## Interface
- STEP_CYCLES, 50000, idle cycles between successive duty steps; at 50 MHz this is 1 ms; legal range ≥1.
- STEP_W, $clog2(STEP_CYCLES+1), step-timer counter width; derived, never overridden.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_dir_en  in  12  per motor i: bit 2i+1 = direction, bit 2i = on/off.
- cmd_duty  in  5  target duty cycle, 0–31.
- avm_address  out  1  0 = direction/enable register, 1 = duty register.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data, zero-extended.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in every state except IDLE.
- cur_duty  out  5  duty value last written to the slave.

## Operation
- **States:** INIT_DIR, INIT_DUTY, IDLE, WAIT, WR_DUTY, WR_DIR.
- **Internal registers:**
  - cur_dir[11:0], cur_duty[4:0]: last values written to the slave.
  - tgt_dir, tgt_duty: latched command.
  - dir_pending: tgt_dir != cur_dir.
- **Reset:**
  - State goes to INIT_DIR; cur_dir = 0, cur_duty = 0, tgt_* = 0, step timer = 0.
  - Output values: avm_write = 0, avm_address = 0, avm_writedata = 0, cmd_ready = 0, busy = 1.
- **INIT_DIR:** write address 0, data 0. On the cycle with waitrequest = 0, go to INIT_DUTY.
- **INIT_DUTY:** write address 1, data 0. On completion, go to IDLE.
- **IDLE:**
  - cmd_ready = 1 only in this state.
  - On cmd_valid: latch tgt_dir = cmd_dir_en, tgt_duty = cmd_duty, set dir_pending, then evaluate DECIDE.
- **DECIDE** (combinational; used from IDLE-accept, WR_DUTY completion and WR_DIR completion):
  - goal = (dir_pending && cur_duty != 0) ? 0 : tgt_duty.
  - If dir_pending and cur_duty == 0 → WR_DIR.
  - Else if cur_duty != goal → WAIT, with timer loaded to STEP_CYCLES-1.
  - Else → IDLE.
- **WAIT:** decrement the timer. When it reaches 0, go to WR_DUTY.
- **WR_DUTY:**
  - Drive avm_address = 1 and avm_writedata = {27'b0, nxt}, where nxt = cur_duty+1 if goal > cur_duty, else cur_duty-1.
  - Hold avm_write, address and data stable while waitrequest = 1.
  - On the completing cycle: cur_duty ← nxt, then DECIDE.
- **WR_DIR:**
  - Drive avm_address = 0 and avm_writedata = {20'b0, tgt_dir}; hold while stalled.
  - On completion: cur_dir ← tgt_dir, dir_pending ← 0, then DECIDE.
- **Redundant commands:** a command equal to (cur_dir, cur_duty) returns to IDLE with no bus write.
- **Arithmetic:** duty steps are exactly ±1 and never wrap; 31 and 0 are endpoints, never stepped past.
- **Reset mid-operation:** the sequence aborts and init is re-run. Dropping avm_write while stalled is permitted only under reset, which the interconnect shares.

## Timing
- Command accept edge T (cmd_valid & cmd_ready). The FSM leaves IDLE at T+1 and cmd_ready is 0 from T+1.
- With waitrequest = 0:
  - Each duty step costs STEP_CYCLES (WAIT) + 1 (write) cycles.
  - A direction-only write is asserted at T+1 and lasts 1 cycle.
- The first duty write of a ramp is asserted at T+1+STEP_CYCLES.
- cur_duty updates on the edge that completes the write, visible the cycle after.
- Back to IDLE (cmd_ready = 1) on the cycle after the final completing write.
- Each stall cycle adds exactly one cycle; there is no timeout.
- Reset to first IDLE: 2 cycles with no stalls.

## Structure
- **Shared package `motor_pkg`:** REG_DIR = 0, REG_DUTY = 1, DIR_W = 12, DUTY_W = 5, NUM_MOTORS = 6, and the state enum. The slave controller uses the same register constants.
- **Sub-module `ramp_step_timer`:** load/decrement counter of width STEP_W with a `done` flag; synchronous reset to 0.

## Test plan
- **Reset:** release reset with waitrequest = 0 → write (addr 0, data 0) then (addr 1, data 0); cmd_ready = 1 at cycle 3; cur_duty = 0.
- **Ramp up:** STEP_CYCLES = 4, command dir 0x001, duty 3 → dir write at T+1, then duty writes 1, 2, 3, each separated by 4 idle cycles; busy falls after the write of 3.
- **Direction change while running:** cur_duty = 2, dir 0x001; command dir 0x003, duty 2 → duty writes 1, 0; then dir write 0x003; then duty writes 1, 2.
- **Wait-state hold:** waitrequest held high 3 cycles during the duty write of value 5 → avm_write, address and data stable for 4 cycles; cur_duty updates only after release; step timing then resumes.
- **Redundant command:** command equal to the current state → no avm_write; cmd_ready high again 1 cycle after accept.
- **Reset mid-ramp:** ramp 0→10 with reset asserted at duty 4 → avm_write = 0 next cycle; init writes (0, 0) re-run; cur_duty = 0.
